// File: rtl/irq_pending_ctrl.sv
// Interrupt-pending controller: rising-edge capture of request lines into a
// pending register, software masking, highest-index priority selection and a
// valid/ready presentation of one interrupt ID at a time.
module irq_pending_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          mask_wr,
    input  logic [N-1:0]  mask_in,
    output logic [N-1:0]  mask,
    output logic [N-1:0]  pending,
    output logic          irq_valid,
    output logic [IW-1:0] irq_id,
    input  logic          irq_ready,
    output logic          any_pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  req_q, req_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  mask_q, mask_d;
    logic          irq_valid_q, irq_valid_d;
    logic [IW-1:0] irq_id_q, irq_id_d;

    logic [N-1:0]  rise;
    logic [N-1:0]  clr;
    logic [N-1:0]  eff;
    logic [IW-1:0] enc;
    logic          eff_zero;
    logic          handshake;

    // Highest-index priority encoder over the unmasked pending bits.
    always_comb begin
        eff      = pending_q & ~mask_q;
        eff_zero = ~|eff;
        enc      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eff[i]) begin
                enc = IW'(i);
            end
        end
    end

    // Next-state logic: edge capture, pending set/clear, mask load, presentation FSM.
    always_comb begin
        req_d       = req;
        mask_d      = mask_q;
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        clr         = '0;

        rise      = req & ~req_q;
        handshake = irq_valid_q & irq_ready;

        if (handshake) begin
            clr[irq_id_q] = 1'b1;
        end
        // A fresh edge on the served line in the ack cycle keeps the bit set.
        pending_d = (pending_q & ~clr) | rise;

        if (mask_wr) begin
            mask_d = mask_in;
        end

        case (state_q)
            IDLE: begin
                if (!eff_zero) begin
                    state_d     = PRESENT;
                    irq_valid_d = 1'b1;
                    irq_id_d    = enc;
                end
            end
            PRESENT: begin
                // The presented ID is held until accepted: no preemption, no retraction.
                if (handshake) begin
                    state_d     = IDLE;
                    irq_valid_d = 1'b0;
                    irq_id_d    = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                irq_valid_d = 1'b0;
                irq_id_d    = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign mask        = mask_q;
    assign pending     = pending_q;
    assign irq_valid   = irq_valid_q;
    assign irq_id      = irq_id_q;
    assign any_pending = ~eff_zero;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with a scoreboard of expected interrupt IDs.
module tb_irq_pending_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          mask_wr;
    logic [N-1:0]  mask_in;
    logic [N-1:0]  mask;
    logic [N-1:0]  pending;
    logic          irq_valid;
    logic [IW-1:0] irq_id;
    logic          irq_ready;
    logic          any_pending;

    int n_cmp;
    int n_bad;
    int exp_q[$];

    irq_pending_ctrl #(.N(N), .IW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mask_wr     (mask_wr),
        .mask_in     (mask_in),
        .mask        (mask),
        .pending     (pending),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id),
        .irq_ready   (irq_ready),
        .any_pending (any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect an ID being presented; compare it with the oldest scoreboard entry.
    task automatic chk_present(input string tag);
        int e;
        chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_sb observed=%0h expected=<scoreboard entry>", tag, irq_id);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_id"}, 32'(irq_id), 32'(e));
        end
    endtask

    // Expect the idle output state.
    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(irq_valid), 32'd0);
        chk({tag, "_id"}, 32'(irq_id), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req       = '0;
        mask_wr   = 1'b0;
        mask_in   = '0;
        irq_ready = 1'b0;
        step();
        step();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_mask", 32'(mask), 32'h0);
        chk("rst_any", 32'(any_pending), 32'h0);
        chk_idle("rst");
        rst_n = 1'b1;

        // Two lines; highest index served first, then the lower one.
        req = 4'b0101;
        exp_q.push_back(2);
        exp_q.push_back(0);
        step();
        chk("t1_pend_e1", 32'(pending), 32'h5);
        chk("t1_valid_e1", 32'(irq_valid), 32'd0);
        step();
        chk_present("t1_e2");
        irq_ready = 1'b1;
        step();
        chk("t1_pend_e3", 32'(pending), 32'h1);
        chk_idle("t1_e3");
        irq_ready = 1'b0;
        step();
        chk_present("t1_e4");
        irq_ready = 1'b1;
        step();
        chk("t1_pend_e5", 32'(pending), 32'h0);
        chk("t1_any_e5", 32'(any_pending), 32'h0);
        chk_idle("t1_e5");
        irq_ready = 1'b0;
        req = '0;
        step();

        // No preemption: id 1 held while a higher line arrives.
        req = 4'b0010;
        exp_q.push_back(1);
        exp_q.push_back(3);
        step();
        step();
        chk_present("t2_first");
        req = 4'b1010;
        step();
        chk("t2_hold_id", 32'(irq_id), 32'd1);
        chk("t2_pend", 32'(pending), 32'ha);
        step();
        chk("t2_hold_id2", 32'(irq_id), 32'd1);
        chk("t2_hold_valid", 32'(irq_valid), 32'd1);
        irq_ready = 1'b1;
        step();
        chk_idle("t2_ack1");
        chk("t2_pend_ack1", 32'(pending), 32'h8);
        irq_ready = 1'b0;
        step();
        chk_present("t2_second");
        irq_ready = 1'b1;
        step();
        chk("t2_pend_ack2", 32'(pending), 32'h0);
        irq_ready = 1'b0;
        req = '0;
        step();

        // Masked line stays pending but invisible until unmasked.
        mask_wr = 1'b1;
        mask_in = 4'b1000;
        step();
        chk("t3_mask", 32'(mask), 32'h8);
        mask_wr = 1'b0;
        req = 4'b1000;
        step();
        chk("t3_pend", 32'(pending), 32'h8);
        chk("t3_any", 32'(any_pending), 32'h0);
        irq_ready = 1'b1;
        step();
        chk_idle("t3_masked");
        chk("t3_pend_hold", 32'(pending), 32'h8);
        irq_ready = 1'b0;
        mask_wr = 1'b1;
        mask_in = 4'b0000;
        exp_q.push_back(3);
        step();
        chk("t3_unmask", 32'(mask), 32'h0);
        chk("t3_any_unmask", 32'(any_pending), 32'h1);
        chk("t3_valid_w", 32'(irq_valid), 32'd0);
        mask_wr = 1'b0;
        step();
        chk_present("t3_unmasked");
        irq_ready = 1'b1;
        step();
        chk("t3_pend_ack", 32'(pending), 32'h0);
        irq_ready = 1'b0;
        req = '0;
        step();

        // Set wins over clear on the acknowledge edge.
        req = 4'b0100;
        exp_q.push_back(2);
        exp_q.push_back(2);
        step();
        step();
        chk_present("t4_first");
        req = 4'b0000;
        step();
        chk("t4_hold_id", 32'(irq_id), 32'd2);
        req = 4'b0100;
        irq_ready = 1'b1;
        step();
        chk("t4_pend_setwins", 32'(pending), 32'h4);
        chk_idle("t4_ack");
        irq_ready = 1'b0;
        step();
        chk_present("t4_again");
        irq_ready = 1'b1;
        step();
        chk("t4_pend_clear", 32'(pending), 32'h0);
        irq_ready = 1'b0;
        req = '0;
        step();

        // Reset mid-handshake; request held through reset re-arms on release.
        req = 4'b1010;
        mask_wr = 1'b1;
        mask_in = 4'b0001;
        exp_q.push_back(3);
        step();
        mask_wr = 1'b0;
        chk("t5_pend", 32'(pending), 32'ha);
        step();
        chk_present("t5_pre_rst");
        rst_n = 1'b0;
        step();
        chk("t5_rst_pend", 32'(pending), 32'h0);
        chk("t5_rst_mask", 32'(mask), 32'h0);
        chk_idle("t5_rst");
        rst_n = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(1);
        step();
        chk("t5_rearm", 32'(pending), 32'ha);
        step();
        chk_present("t5_post1");
        irq_ready = 1'b1;
        step();
        chk("t5_pend_ack1", 32'(pending), 32'h2);
        irq_ready = 1'b0;
        step();
        chk_present("t5_post2");
        irq_ready = 1'b1;
        step();
        chk("t5_pend_ack2", 32'(pending), 32'h0);
        irq_ready = 1'b0;
        req = '0;
        step();

        // Repeated edges on a pending line merge into one presentation.
        req = 4'b0001;
        exp_q.push_back(0);
        step();
        chk("t6_pend", 32'(pending), 32'h1);
        req = 4'b0000;
        step();
        chk_present("t6_present");
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        req = 4'b0001;
        step();
        chk("t6_pend_merged", 32'(pending), 32'h1);
        chk("t6_hold_id", 32'(irq_id), 32'd0);
        irq_ready = 1'b1;
        step();
        chk("t6_pend_ack", 32'(pending), 32'h0);
        chk_idle("t6_ack");
        irq_ready = 1'b0;
        req = '0;
        step();
        step();
        chk_idle("t6_stay_idle");
        chk("t6_any", 32'(any_pending), 32'h0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
